frame_buf_mem_init: RTL and testbench

Memory-side initiator for the frame buffer: accepts a pixel write stream and single-pixel read requests, and drives the active-low, two-cycle-access frame memory interface (`wr_addr`/`rd_addr`/`wr_data`/`wr_en`/`rd_en`/`rd_data`). It sits between the pixel source/display logic and the frame memory. It arbitrates reads and writes, generates sequential wrapping frame addresses, and returns read data with a valid strobe.

---
 rtl/frame_buf_mem_init.sv | 212 +++++++++++++++++++++
 tb/tb_frame_buf_mem_init.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_mem_init.sv
// frame_buf_mem_init
//
// Memory-side initiator for the frame buffer. Accepts a pixel write stream
// and single-pixel read requests, arbitrates between them, and drives a
// two-cycle-access frame memory with active-low enables. Pixel index i lives
// at memory address ADDR_OFFSET + i; both pointers wrap after FRAME_PIXELS.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   reset          asynchronous, active-low reset
//   in_data        pixel to write
//   in_valid       in_data is valid
//   in_ready       write holding register is empty
//   rd_req         pulse: fetch the next pixel
//   rd_busy        a read is pending or in flight
//   out_data       read pixel
//   out_valid      one-cycle strobe, out_data is valid
//   wr_frame_done  one-cycle pulse after the last pixel of a frame is written
//   mem_wr_addr    memory write address (registered)
//   mem_rd_addr    memory read address (registered)
//   mem_wr_data    memory write data (registered)
//   mem_wr_en      active-low memory write enable (registered)
//   mem_rd_en      active-low memory read enable (registered)
//   mem_rd_data    memory read data
//   state_dbg      current FSM state, for observation only
//
// Handshake: a write transfer happens on a rising edge where
// in_valid & in_ready are both high; in_valid may be held while in_ready is
// low and no transfer occurs. A read request is taken on a rising edge where
// rd_req is high and rd_busy is low; a request while busy is dropped.

module frame_buf_mem_init #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 29,
    parameter int FRAME_PIXELS = 307200,
    parameter int ADDR_OFFSET  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  rd_req,
    output logic                  rd_busy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  wr_frame_done,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [2:0]            state_dbg
);

    localparam int PTR_W = $clog2(FRAME_PIXELS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_SETUP   = 3'd1,
        WR_HOLD    = 3'd2,
        RD_SETUP   = 3'd3,
        RD_HOLD    = 3'd4,
        RD_CAPTURE = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] hold_data, hold_data_nxt;
    logic                  wr_pend, wr_pend_nxt;
    logic                  rd_pend, rd_pend_nxt;
    // 1 when the most recent contested arbitration went to the read port.
    logic                  last_rd, last_rd_nxt;
    logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]      rd_ptr, rd_ptr_nxt;

    logic [ADDR_WIDTH-1:0] mem_wr_addr_nxt, mem_rd_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wr_data_nxt, out_data_nxt;
    logic                  mem_wr_en_nxt, mem_rd_en_nxt;
    logic                  out_valid_nxt, wr_frame_done_nxt;

    logic                  grant_wr, grant_rd;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    assign wr_addr   = ADDR_WIDTH'(ADDR_OFFSET) + ADDR_WIDTH'(wr_ptr);
    assign rd_addr   = ADDR_WIDTH'(ADDR_OFFSET) + ADDR_WIDTH'(rd_ptr);
    assign in_ready  = !wr_pend;
    assign rd_busy   = rd_pend || (state == RD_SETUP) || (state == RD_HOLD) ||
                       (state == RD_CAPTURE);
    assign state_dbg = state;

    // Arbitration. last_rd only moves on a contested grant, so an
    // uncontested read or write does not change who wins the next tie.
    always_comb begin
        grant_wr    = 1'b0;
        grant_rd    = 1'b0;
        last_rd_nxt = last_rd;
        if (state == IDLE) begin
            if (wr_pend && rd_pend) begin
                grant_wr    = last_rd;
                grant_rd    = !last_rd;
                last_rd_nxt = !last_rd;
            end else if (wr_pend) begin
                grant_wr = 1'b1;
            end else if (rd_pend) begin
                grant_rd = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        hold_data_nxt     = hold_data;
        wr_pend_nxt       = wr_pend;
        rd_pend_nxt       = rd_pend;
        wr_ptr_nxt        = wr_ptr;
        rd_ptr_nxt        = rd_ptr;
        mem_wr_addr_nxt   = mem_wr_addr;
        mem_rd_addr_nxt   = mem_rd_addr;
        mem_wr_data_nxt   = mem_wr_data;
        mem_wr_en_nxt     = mem_wr_en;
        mem_rd_en_nxt     = mem_rd_en;
        out_data_nxt      = out_data;
        out_valid_nxt     = 1'b0;
        wr_frame_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_nxt       = WR_SETUP;
                    mem_wr_en_nxt   = 1'b0;
                    mem_wr_addr_nxt = wr_addr;
                    mem_wr_data_nxt = hold_data;
                end else if (grant_rd) begin
                    state_nxt       = RD_SETUP;
                    mem_rd_en_nxt   = 1'b0;
                    mem_rd_addr_nxt = rd_addr;
                end
            end
            WR_SETUP: state_nxt = WR_HOLD;
            WR_HOLD: begin
                state_nxt         = IDLE;
                mem_wr_en_nxt     = 1'b1;
                wr_pend_nxt       = 1'b0;
                wr_frame_done_nxt = (wr_ptr == LAST_IDX);
                wr_ptr_nxt        = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
            end
            RD_SETUP: state_nxt = RD_HOLD;
            RD_HOLD: begin
                state_nxt     = RD_CAPTURE;
                mem_rd_en_nxt = 1'b1;
            end
            RD_CAPTURE: begin
                state_nxt     = IDLE;
                out_data_nxt  = mem_rd_data;
                out_valid_nxt = 1'b1;
                rd_pend_nxt   = 1'b0;
                rd_ptr_nxt    = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_W'(1);
            end
            default: state_nxt = IDLE;
        endcase

        // Accepts never collide with the clears above: a pend flag is only
        // cleared while it is set, and only accepted while it is clear.
        if (in_valid && !wr_pend) begin
            wr_pend_nxt   = 1'b1;
            hold_data_nxt = in_data;
        end
        if (rd_req && !rd_busy) begin
            rd_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            hold_data     <= '0;
            wr_pend       <= 1'b0;
            rd_pend       <= 1'b0;
            last_rd       <= 1'b1;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            mem_wr_addr   <= '0;
            mem_rd_addr   <= '0;
            mem_wr_data   <= '0;
            mem_wr_en     <= 1'b1;
            mem_rd_en     <= 1'b1;
            out_data      <= '0;
            out_valid     <= 1'b0;
            wr_frame_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            hold_data     <= hold_data_nxt;
            wr_pend       <= wr_pend_nxt;
            rd_pend       <= rd_pend_nxt;
            last_rd       <= last_rd_nxt;
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            mem_wr_addr   <= mem_wr_addr_nxt;
            mem_rd_addr   <= mem_rd_addr_nxt;
            mem_wr_data   <= mem_wr_data_nxt;
            mem_wr_en     <= mem_wr_en_nxt;
            mem_rd_en     <= mem_rd_en_nxt;
            out_data      <= out_data_nxt;
            out_valid     <= out_valid_nxt;
            wr_frame_done <= wr_frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_frame_buf_mem_init.sv
// Bench for frame_buf_mem_init with a small frame (4 pixels) so that wrap,
// frame-done and arbitration corners are reached quickly.

module tb_frame_buf_mem_init;

    localparam int DW  = 32;
    localparam int AW  = 29;
    localparam int FP  = 4;
    localparam int OFF = 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          rd_req = 1'b0;
    logic          rd_busy;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          wr_frame_done;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_en, mem_rd_en;
    logic [DW-1:0] mem_rd_data = '0;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    frame_buf_mem_init #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_PIXELS(FP), .ADDR_OFFSET(OFF)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rd_req(rd_req), .rd_busy(rd_busy),
        .out_data(out_data), .out_valid(out_valid),
        .wr_frame_done(wr_frame_done),
        .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .state_dbg(state_dbg)
    );

    // Frame memory: writes while the write enable is low, read data follows
    // the read address while the read enable is low.
    logic [DW-1:0] mem [0:15];
    always @(posedge clk) begin
        if (!mem_wr_en) mem[mem_wr_addr[3:0]] <= mem_wr_data;
        if (!mem_rd_en) mem_rd_data <= mem[mem_rd_addr[3:0]];
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            len;
        bit            stable;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            start;
    } burst_t;

    burst_t        wr_ev_q[$], rd_ev_q[$];
    burst_t        wr_cur, rd_cur;
    logic [DW-1:0] ov_q[$];
    int            ov_cyc_q[$];
    logic [AW-1:0] fd_q[$];

    logic [AW-1:0] exp_wr_addr_q[$];
    logic [DW-1:0] exp_wr_data_q[$];
    int            exp_wr_start_q[$];
    logic [AW-1:0] exp_rd_addr_q[$];
    logic [DW-1:0] exp_q[$];
    int            exp_rd_start_q[$];
    int            exp_ov_cyc_q[$];
    logic [AW-1:0] exp_fd_q[$];

    // Observation of the memory side, sampled on the falling edge.
    initial begin
        wr_cur.len = 0;
        rd_cur.len = 0;
    end

    always @(negedge clk) begin
        if (!mem_wr_en || !mem_rd_en)
            chk("en_overlap", 64'(!mem_wr_en && !mem_rd_en), 64'd0);
        if (!mem_wr_en) begin
            if (wr_cur.len == 0) begin
                wr_cur.addr = mem_wr_addr; wr_cur.data = mem_wr_data;
                wr_cur.stable = 1'b1; wr_cur.start = cyc;
            end else if (mem_wr_addr !== wr_cur.addr || mem_wr_data !== wr_cur.data) begin
                wr_cur.stable = 1'b0;
            end
            wr_cur.len++;
        end else if (wr_cur.len != 0) begin
            wr_ev_q.push_back(wr_cur);
            wr_cur.len = 0;
        end
        if (!mem_rd_en) begin
            if (rd_cur.len == 0) begin
                rd_cur.addr = mem_rd_addr; rd_cur.data = '0;
                rd_cur.stable = 1'b1; rd_cur.start = cyc;
            end else if (mem_rd_addr !== rd_cur.addr) begin
                rd_cur.stable = 1'b0;
            end
            rd_cur.len++;
        end else if (rd_cur.len != 0) begin
            rd_ev_q.push_back(rd_cur);
            rd_cur.len = 0;
        end
        if (out_valid) begin
            ov_q.push_back(out_data);
            ov_cyc_q.push_back(cyc);
        end
        if (wr_frame_done) fd_q.push_back(mem_wr_addr);
    end

    task automatic clear_obs();
        wr_ev_q.delete(); rd_ev_q.delete(); ov_q.delete(); ov_cyc_q.delete(); fd_q.delete();
        exp_wr_addr_q.delete(); exp_wr_data_q.delete(); exp_wr_start_q.delete();
        exp_rd_addr_q.delete(); exp_q.delete(); exp_rd_start_q.delete();
        exp_ov_cyc_q.delete(); exp_fd_q.delete();
    endtask

    // Compare everything observed since the last drain with what was expected.
    // A start/ov cycle of -1 means the timing is not checked for that entry.
    task automatic drain();
        burst_t b;
        int     es, eo, oc;
        logic [DW-1:0] od;
        chk("wr_count", wr_ev_q.size(), exp_wr_addr_q.size());
        while (wr_ev_q.size() != 0 && exp_wr_addr_q.size() != 0) begin
            b  = wr_ev_q.pop_front();
            es = exp_wr_start_q.pop_front();
            chk("wr_len", b.len, 2);
            chk("wr_stable", b.stable, 1);
            chk("wr_addr", b.addr, exp_wr_addr_q.pop_front());
            chk("wr_data", b.data, exp_wr_data_q.pop_front());
            if (es >= 0) chk("wr_start", b.start, es);
        end
        chk("rd_count", rd_ev_q.size(), exp_rd_addr_q.size());
        while (rd_ev_q.size() != 0 && exp_rd_addr_q.size() != 0) begin
            b  = rd_ev_q.pop_front();
            es = exp_rd_start_q.pop_front();
            chk("rd_len", b.len, 2);
            chk("rd_stable", b.stable, 1);
            chk("rd_addr", b.addr, exp_rd_addr_q.pop_front());
            if (es >= 0) chk("rd_start", b.start, es);
        end
        chk("ov_count", ov_q.size(), exp_q.size());
        while (ov_q.size() != 0 && exp_q.size() != 0) begin
            od = ov_q.pop_front();
            oc = ov_cyc_q.pop_front();
            eo = exp_ov_cyc_q.pop_front();
            chk("out_data", od, exp_q.pop_front());
            if (eo >= 0) chk("ov_cycle", oc, eo);
        end
        chk("fd_count", fd_q.size(), exp_fd_q.size());
        while (fd_q.size() != 0 && exp_fd_q.size() != 0)
            chk("fd_addr", fd_q.pop_front(), exp_fd_q.pop_front());
        clear_obs();
    endtask

    // ---------------- reference model ----------------
    // Pixel index bookkeeping straight from the addressing rules: index i sits
    // at OFF + i, indices wrap modulo FP, ties alternate starting with write.
    int            m_wr_idx = 0;
    int            m_rd_idx = 0;
    bit            m_last_rd = 1'b1;
    logic [DW-1:0] model_mem [0:15];

    task automatic model_write(input logic [DW-1:0] d, input int start);
        logic [AW-1:0] a;
        a = AW'(OFF + m_wr_idx);
        exp_wr_addr_q.push_back(a);
        exp_wr_data_q.push_back(d);
        exp_wr_start_q.push_back(start);
        model_mem[a[3:0]] = d;
        if (m_wr_idx == FP - 1) exp_fd_q.push_back(a);
        m_wr_idx = (m_wr_idx + 1) % FP;
    endtask

    task automatic model_read(input int start, input int ov);
        logic [AW-1:0] a;
        a = AW'(OFF + m_rd_idx);
        exp_rd_addr_q.push_back(a);
        exp_q.push_back(model_mem[a[3:0]]);
        exp_rd_start_q.push_back(start);
        exp_ov_cyc_q.push_back(ov);
        m_rd_idx = (m_rd_idx + 1) % FP;
    endtask

    // ---------------- drivers (called on a falling edge) ----------------
    task automatic send_write(input logic [DW-1:0] d, output int c);
        chk("in_ready_at_send", in_ready, 1);
        in_valid = 1'b1; in_data = d; c = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_read(output int c);
        rd_req = 1'b1; c = cyc;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // Write and read request on the same edge; the model decides the order.
    task automatic send_both(input logic [DW-1:0] d);
        int c;
        in_valid = 1'b1; in_data = d; rd_req = 1'b1; c = cyc;
        @(negedge clk);
        in_valid = 1'b0; rd_req = 1'b0;
        if (m_last_rd) begin
            model_write(d, c + 2);
            model_read(c + 5, c + 8);
        end else begin
            model_read(c + 2, c + 5);
            model_write(d, c + 6);
        end
        m_last_rd = !m_last_rd;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(in_ready && !rd_busy && mem_wr_en && mem_rd_en && state_dbg == 3'd0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_budget", 64'(n < 40), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        bit            is_rd;
        logic [DW-1:0] wdata;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        bit            fd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int c;
        int op;
        logic [DW-1:0] d;

        tbl[0] = '{1'b0, 32'hA5A5_0001, 29'd1, 32'h0, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0011, 29'd2, 32'h0, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_0022, 29'd3, 32'h0, 1'b0};
        tbl[3] = '{1'b0, 32'h0000_0033, 29'd4, 32'h0, 1'b1};
        tbl[4] = '{1'b0, 32'h0000_0044, 29'd1, 32'h0, 1'b0};
        tbl[5] = '{1'b1, 32'h0, 29'd1, 32'h0000_0044, 1'b0};
        tbl[6] = '{1'b1, 32'h0, 29'd2, 32'h0000_0011, 1'b0};
        tbl[7] = '{1'b1, 32'h0, 29'd3, 32'h0000_0022, 1'b0};
        tbl[8] = '{1'b1, 32'h0, 29'd4, 32'h0000_0033, 1'b0};
        tbl[9] = '{1'b1, 32'h0, 29'd1, 32'h0000_0044, 1'b0};

        // Reset values.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_wr_en", mem_wr_en, 1);
        chk("rst_mem_rd_en", mem_rd_en, 1);
        chk("rst_mem_wr_addr", mem_wr_addr, 0);
        chk("rst_mem_rd_addr", mem_rd_addr, 0);
        chk("rst_mem_wr_data", mem_wr_data, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wr_frame_done", wr_frame_done, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_state", state_dbg, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a write: enables release at once.
        send_write(32'hDEAD_BEEF, c);
        @(negedge clk);
        chk("midwr_en_low", mem_wr_en, 0);
        #2 reset = 1'b0;
        #1;
        chk("midwr_rst_wr_en", mem_wr_en, 1);
        chk("midwr_rst_in_ready", in_ready, 1);
        chk("midwr_rst_out_valid", out_valid, 0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        clear_obs();

        // Reset in the middle of a read: no out_valid, no pointer advance.
        send_read(c);
        @(negedge clk);
        chk("midrd_en_low", mem_rd_en, 0);
        #2 reset = 1'b0;
        #1;
        chk("midrd_rst_rd_en", mem_rd_en, 1);
        chk("midrd_rst_rd_busy", rd_busy, 0);
        @(negedge clk) reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrd_no_out_valid", ov_q.size(), 0);
        clear_obs();

        // Table: writes through a frame wrap, then reads through a wrap.
        for (int i = 0; i < 10; i++) begin
            if (!tbl[i].is_rd) begin
                send_write(tbl[i].wdata, c);
                exp_wr_addr_q.push_back(tbl[i].addr);
                exp_wr_data_q.push_back(tbl[i].wdata);
                exp_wr_start_q.push_back(c + 2);
                if (tbl[i].fd) exp_fd_q.push_back(tbl[i].addr);
                repeat (2) @(negedge clk);
                chk("in_ready_low_in_access", in_ready, 0);
                @(negedge clk);
                chk("in_ready_returns", in_ready, 1);
            end else begin
                send_read(c);
                chk("rd_busy_after_req", rd_busy, 1);
                exp_rd_addr_q.push_back(tbl[i].addr);
                exp_q.push_back(tbl[i].rdata);
                exp_rd_start_q.push_back(c + 2);
                exp_ov_cyc_q.push_back(c + 5);
            end
            wait_idle();
            drain();
            if (!tbl[i].is_rd) chk("mem_content", mem[tbl[i].addr[3:0]], tbl[i].wdata);
        end

        // Model state after the table.
        m_wr_idx = 1; m_rd_idx = 1; m_last_rd = 1'b1;
        model_mem[1] = 32'h44; model_mem[2] = 32'h11;
        model_mem[3] = 32'h22; model_mem[4] = 32'h33;

        // Two simultaneous pairs: write first, then read first.
        send_both(32'h5151_0001);
        wait_idle();
        drain();
        send_both(32'h5151_0002);
        wait_idle();
        drain();

        // Read request while busy is dropped.
        send_read(c);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        model_read(c + 2, c + 5);
        wait_idle();
        drain();
        send_read(c);
        model_read(c + 2, c + 5);
        wait_idle();
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 2);
            d  = $urandom;
            if (op == 0) begin
                send_write(d, c);
                model_write(d, c + 2);
            end else if (op == 1) begin
                send_read(c);
                model_read(c + 2, c + 5);
            end else begin
                send_both(d);
            end
            wait_idle();
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
